// File: rtl/oven_button_conditioner.sv
// rtl/oven_button_conditioner.sv - oven key synchroniser, debouncer and inc/dec step generator
// Bit 0 of the per-key vectors is the top (up) key, bit 1 the bottom (down) key.
module oven_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_DELAY      = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_up_n,
   input  logic key_dn_n,
   input  logic enable,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic up_held,
   output logic dn_held,
   output logic repeat_active
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int T_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int TM_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_DELAY - 1);
   localparam logic [TM_W-1:0] RPT_LAST  = TM_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT, LOCKOUT} state_t;

   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      deb_q, prev_q;
   logic [DB_W-1:0] cnt_q [2];
   logic [1:0]      press;

   state_t          state_q, state_d;
   logic            dir_q, dir_d;
   logic [TM_W-1:0] timer_q, timer_d;
   logic [TM_W-1:0] limit;
   logic            inc_q, dec_q, inc_d, dec_d;
   logic            fire, dir_held, other_held;

   // Raw levels are 1 = released; deb_q/prev_q hold 1 = pressed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 2'b11;
         sync2_q  <= 2'b11;
         deb_q    <= 2'b00;
         prev_q   <= 2'b00;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         sync1_q <= {key_dn_n, key_up_n};
         sync2_q <= sync1_q;
         prev_q  <= deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               if (cnt_q[i] == DB_LAST) begin
                  deb_q[i] <= ~sync2_q[i];
                  cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign press      = deb_q & ~prev_q;
   assign dir_held   = dir_q ? deb_q[1] : deb_q[0];
   assign other_held = dir_q ? deb_q[0] : deb_q[1];
   assign limit      = (state_q == REPEAT) ? RPT_LAST : HOLD_LAST;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      fire    = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         timer_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               timer_d = '0;
               if (press[0] && press[1]) begin
                  state_d = LOCKOUT;
               end else if (press[0] || press[1]) begin
                  // A press while the other key is already down is a lockout, not a step.
                  if ((press[0] && deb_q[1]) || (press[1] && deb_q[0])) begin
                     state_d = LOCKOUT;
                  end else begin
                     dir_d   = press[1];
                     fire    = 1'b1;
                     state_d = HOLD_WAIT;
                  end
               end
            end
            HOLD_WAIT, REPEAT: begin
               if (!dir_held) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else if (other_held) begin
                  state_d = LOCKOUT;
                  timer_d = '0;
               end else if (timer_q == limit) begin
                  fire    = 1'b1;
                  state_d = REPEAT;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            LOCKOUT: begin
               timer_d = '0;
               if (deb_q == 2'b00) state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               timer_d = '0;
            end
         endcase
      end
      inc_d = fire & ~dir_d;
      dec_d = fire & dir_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         timer_q <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         timer_q <= timer_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
      end
   end

   assign inc_pulse     = inc_q;
   assign dec_pulse     = dec_q;
   assign up_held       = deb_q[0];
   assign dn_held       = deb_q[1];
   assign repeat_active = (state_q == REPEAT);

endmodule

// File: tb/tb_oven_button_conditioner.sv
// tb/tb_oven_button_conditioner.sv - directed bench for oven_button_conditioner
// Edge k is the posedge that sets cyc to k; drives and samples happen on negedges.
module tb_oven_button_conditioner;

   logic clk = 1'b0;
   logic rst_n, key_up_n, key_dn_n, enable;
   logic inc_pulse, dec_pulse, up_held, dn_held, repeat_active;

   int cyc = 0;
   int n_asrt = 0;
   int n_fail = 0;
   int inc_times[$];
   int dec_times[$];
   int overlap_cnt = 0;
   int wide_cnt = 0;
   int dn_seen = 0;
   logic inc_prev = 1'b0;
   logic dec_prev = 1'b0;

   oven_button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_DELAY(20),
      .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_up_n(key_up_n),
      .key_dn_n(key_dn_n),
      .enable(enable),
      .inc_pulse(inc_pulse),
      .dec_pulse(dec_pulse),
      .up_held(up_held),
      .dn_held(dn_held),
      .repeat_active(repeat_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (inc_pulse) inc_times.push_back(cyc);
      if (dec_pulse) dec_times.push_back(cyc);
      if (inc_pulse && dec_pulse) overlap_cnt <= overlap_cnt + 1;
      if ((inc_pulse && inc_prev) || (dec_pulse && dec_prev)) wide_cnt <= wide_cnt + 1;
      if (dn_held) dn_seen <= dn_seen + 1;
      inc_prev <= inc_pulse;
      dec_prev <= dec_pulse;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic to_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   initial begin
      int k, si, sd, sdn;
      rst_n = 1'b0; key_up_n = 1'b1; key_dn_n = 1'b1; enable = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'({inc_pulse, dec_pulse, up_held, dn_held, repeat_active}), 32'd0);
      rst_n = 1'b1;
      to_edge(cyc + 3);

      // tap
      k = cyc; si = inc_times.size(); sd = dec_times.size();
      key_up_n = 1'b0;
      to_edge(k + 5);  chk("tap_held_early", 32'(up_held), 32'd0);
      to_edge(k + 6);  chk("tap_held", 32'(up_held), 32'd1);
      chk("tap_no_pulse_yet", 32'(inc_pulse), 32'd0);
      to_edge(k + 7);  chk("tap_pulse", 32'(inc_pulse), 32'd1);
      chk("tap_no_dec", 32'(dec_pulse), 32'd0);
      to_edge(k + 8);  chk("tap_pulse_end", 32'(inc_pulse), 32'd0);
      to_edge(k + 12); key_up_n = 1'b1;
      to_edge(k + 30);
      chk("tap_released", 32'(up_held), 32'd0);
      chk("tap_inc_count", 32'(inc_times.size() - si), 32'd1);
      chk("tap_inc_time", 32'(inc_times[si]), 32'(k + 7));
      chk("tap_dec_count", 32'(dec_times.size() - sd), 32'd0);
      chk("tap_no_repeat", 32'(repeat_active), 32'd0);

      // bounce on the down key
      si = inc_times.size(); sd = dec_times.size(); sdn = dn_seen;
      for (int i = 0; i < 10; i++) begin
         key_dn_n = (i % 2 == 1);
         to_edge(cyc + 2);
      end
      key_dn_n = 1'b1;
      to_edge(cyc + 10);
      chk("bounce_dn_held", 32'(dn_seen - sdn), 32'd0);
      chk("bounce_dec", 32'(dec_times.size() - sd), 32'd0);
      chk("bounce_inc", 32'(inc_times.size() - si), 32'd0);

      // hold to repeat
      k = cyc; si = inc_times.size();
      key_up_n = 1'b0;
      to_edge(k + 26); chk("hold_rpt_before", 32'(repeat_active), 32'd0);
      to_edge(k + 27); chk("hold_rpt_start", 32'(repeat_active), 32'd1);
      to_edge(k + 60); key_up_n = 1'b1;
      to_edge(k + 66); chk("hold_rpt_until_release", 32'(repeat_active), 32'd1);
      to_edge(k + 67); chk("hold_rpt_end", 32'(repeat_active), 32'd0);
      to_edge(k + 75);
      chk("hold_inc_count", 32'(inc_times.size() - si), 32'd9);
      for (int j = 0; j < 9; j++) begin
         if (si + j < inc_times.size())
            chk($sformatf("hold_inc_time_%0d", j), 32'(inc_times[si + j]),
                32'((j == 0) ? k + 7 : k + 27 + 5 * (j - 1)));
      end

      // both keys lockout
      k = cyc; si = inc_times.size(); sd = dec_times.size();
      key_up_n = 1'b0;
      to_edge(k + 10); key_dn_n = 1'b0;
      to_edge(k + 30); key_dn_n = 1'b1;
      to_edge(k + 45);
      chk("both_inc_count", 32'(inc_times.size() - si), 32'd1);
      chk("both_dec_count", 32'(dec_times.size() - sd), 32'd0);
      chk("both_no_repeat", 32'(repeat_active), 32'd0);
      key_up_n = 1'b1;
      to_edge(k + 55); key_dn_n = 1'b0;
      to_edge(k + 62); chk("both_dec_pulse", 32'(dec_pulse), 32'd1);
      to_edge(k + 65); key_dn_n = 1'b1;
      to_edge(k + 80);
      chk("both_dec_after", 32'(dec_times.size() - sd), 32'd1);
      chk("both_inc_after", 32'(inc_times.size() - si), 32'd1);

      // enable gating
      k = cyc; si = inc_times.size();
      enable = 1'b0; key_up_n = 1'b0;
      to_edge(k + 15); enable = 1'b1;
      to_edge(k + 40);
      chk("en_held_no_pulse", 32'(inc_times.size() - si), 32'd0);
      key_up_n = 1'b1;
      to_edge(k + 50); key_up_n = 1'b0;
      to_edge(k + 57); chk("en_repress_pulse", 32'(inc_pulse), 32'd1);
      to_edge(k + 77); chk("en_repeat_pulse", 32'(inc_pulse), 32'd1);
      chk("en_repeat_active", 32'(repeat_active), 32'd1);
      to_edge(k + 81); enable = 1'b0;
      to_edge(k + 82);
      chk("en_drop_no_pulse", 32'(inc_pulse), 32'd0);
      chk("en_drop_idle", 32'(repeat_active), 32'd0);
      to_edge(k + 85); key_up_n = 1'b1;
      to_edge(k + 95); enable = 1'b1;
      to_edge(k + 100);
      chk("en_inc_count", 32'(inc_times.size() - si), 32'd2);

      // reset during repeat
      k = cyc;
      key_up_n = 1'b0;
      to_edge(k + 31); chk("rst_in_repeat", 32'(repeat_active), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", 32'({inc_pulse, dec_pulse, up_held, dn_held, repeat_active}), 32'd0);
      key_up_n = 1'b1;
      to_edge(k + 33); rst_n = 1'b1;
      si = inc_times.size(); sd = dec_times.size();
      to_edge(k + 50);
      chk("rst_release_no_pulse", 32'(inc_times.size() - si + dec_times.size() - sd), 32'd0);

      rst_n = 1'b0; key_up_n = 1'b0;
      to_edge(cyc + 2); rst_n = 1'b1;
      k = cyc; si = inc_times.size();
      to_edge(k + 6);  chk("rst_held_up", 32'(up_held), 32'd1);
      to_edge(k + 7);  chk("rst_held_pulse", 32'(inc_pulse), 32'd1);
      to_edge(k + 10); key_up_n = 1'b1;
      to_edge(k + 25);
      chk("rst_held_count", 32'(inc_times.size() - si), 32'd1);

      chk("never_both_pulses", 32'(overlap_cnt), 32'd0);
      chk("single_cycle_pulses", 32'(wide_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
